ps2_key_decoder: RTL
====================

# ps2_key_decoder

Converts the raw PS/2 set-2 byte stream into buffered ASCII key events for the character-buffer writer. Sits between the PS/2 receiver (byte plus one-cycle strobe) and the on-screen character buffer. Handles the break (F0) and extended (E0) prefixes, shift and caps-lock state, and a small show-ahead FIFO, so the consumer sees exactly one ASCII byte per accepted key press.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  in  1  system clock (100 MHz); all logic on rising edge.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  byte from PS/2 receiver; valid only when read_data=1.
- read_data  in  1  one-cycle strobe, new byte available.
- err  in  1  receiver error; qualifies read_data.
- out_ready  in  1  consumer accepts head entry this cycle.
- out_valid  out  1  FIFO non-empty.
- out_data  out  8  ASCII of head entry (show-ahead); 8'h00 when empty.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- caps_on  out  1  current caps-lock state.
- fifo_count  out  $clog2(DEPTH)+1  entries held.

## Operation
- Byte accepted only when read_data=1 and err=0. When read_data=1 and err=1, the byte is discarded and the prefix FSM returns to IDLE.
- Prefix FSM states: IDLE, E0, F0, E0F0.
  - IDLE: F0 → F0; E0 → E0; other byte → make(code) → IDLE.
  - E0: F0 → E0F0; other byte ignored (extended make) → IDLE.
  - E0F0: any byte ignored → IDLE.
  - F0: any byte → break(code) → IDLE.
- Modifiers:
  - lshift (12) and rshift (59) are set on make and cleared on their own break.
  - shift = lshift | rshift.
  - caps_on toggles on make of 58 only when caps_held=0. caps_held is set on make of 58 and cleared on break of 58, so typematic repeats do not toggle.
- Translation, applied on make only. Every make, including typematic repeats, produces an event.
  - Letters use the set-2 codes: a=1C b=32 c=21 d=23 e=24 f=2B g=34 h=33 i=43 j=3B k=42 l=4B m=3A n=31 o=44 p=4D q=15 r=2D s=1B t=2C u=3C v=2A w=1D x=22 y=35 z=1A.
    - Output is uppercase (41-5A) when shift XOR caps_on, else lowercase (61-7A).
  - Digits map to 30-39, unaffected by shift or caps: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46.
  - 29 → 20 (space), 5A → 0D (enter), 66 → 08 (backspace).
  - All other codes, and modifier codes, produce no event.
- FIFO:
  - Circular, DEPTH entries; read and write pointers are $clog2(DEPTH) bits and wrap naturally.
  - Pop when out_valid & out_ready.
  - Push when an event is produced:
    - If count<DEPTH, or a pop occurs in the same cycle, the event is written.
    - Otherwise it is dropped and overflow is set.
  - A push and pop in the same cycle leave count unchanged.
- overflow is cleared only by reset.

## Timing
- Reset values: FSM=IDLE, lshift=rshift=caps_held=caps_on=0, pointers=0, fifo_count=0, out_valid=0, out_data=00, overflow=0.
- Reset mid-sequence, e.g. after F0: the pending prefix is lost and the next byte is treated from IDLE.
- Stage 1: at edge E where read_data=1, the FSM, modifier, and caps state update. A registered event (ev_valid, ev_ascii) is captured, using modifier state from before edge E.
- Stage 2: at edge E+1 the event is pushed. out_valid and fifo_count reflect it after E+1, giving 2-cycle latency from strobe to out_valid.
- Pop at edge P: out_data shows the next entry after P, with no bubble.
- Back-to-back strobes on consecutive cycles are fully supported, one event per byte.
- A caps-lock make at edge E affects the translation of a letter strobed at edge E+1 or later.

## Test plan
- Reset, then bytes 1C, F0, 1C with out_ready=1 → exactly one event 61 ('a'), out_valid high 2 cycles after the 1C strobe; no event from the F0 1C break.
- Bytes 12, 1C, F0, 12, 1C → events 41 then 61. Bytes 58, 58 (repeat), F0, 58, 32 → caps_on=1 and event 42; a second 58 make after the break → caps_on=0.
- Bytes E0, 75, E0, F0, 75, 45 → only event 30; FSM back in IDLE.
- DEPTH=4, out_ready=0, strobes 16, 1E, 26, 25, 2E → fifo_count=4, overflow=1, entries 31 32 33 34. Then out_ready=1 → pops in order, count reaches 0, out_data=00.
- FIFO full with push and pop on the same edge → count stays 4, no overflow, new entry appended.
- Byte F0 followed by reset, then 1C → event 61. Byte F0 with err=1, then 1C → event 61; the errored byte is ignored.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: prefix tracking, shift/caps state, ASCII translation
// and a small show-ahead FIFO of key events.
module ps2_key_decoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     read_data,
    input  logic                     err,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     overflow,
    output logic                     caps_on,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} state_t;

    state_t         state_reg, state_next;
    logic           lshift_reg, lshift_next;
    logic           rshift_reg, rshift_next;
    logic           caps_held_reg, caps_held_next;
    logic           caps_reg, caps_next;
    logic           ev_valid_reg, ev_valid_next;
    logic [7:0]     ev_ascii_reg, ev_ascii_next;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           overflow_reg;

    logic           is_letter, is_fixed;
    logic [7:0]     lower_ascii, fixed_ascii;
    logic           push, pop, wr_en;

    // Lowercase letter lookup plus the case-independent keys.
    always_comb begin
        is_letter   = 1'b1;
        lower_ascii = 8'h00;
        case (rx_data)
            8'h1C: lower_ascii = 8'h61;  8'h32: lower_ascii = 8'h62;
            8'h21: lower_ascii = 8'h63;  8'h23: lower_ascii = 8'h64;
            8'h24: lower_ascii = 8'h65;  8'h2B: lower_ascii = 8'h66;
            8'h34: lower_ascii = 8'h67;  8'h33: lower_ascii = 8'h68;
            8'h43: lower_ascii = 8'h69;  8'h3B: lower_ascii = 8'h6A;
            8'h42: lower_ascii = 8'h6B;  8'h4B: lower_ascii = 8'h6C;
            8'h3A: lower_ascii = 8'h6D;  8'h31: lower_ascii = 8'h6E;
            8'h44: lower_ascii = 8'h6F;  8'h4D: lower_ascii = 8'h70;
            8'h15: lower_ascii = 8'h71;  8'h2D: lower_ascii = 8'h72;
            8'h1B: lower_ascii = 8'h73;  8'h2C: lower_ascii = 8'h74;
            8'h3C: lower_ascii = 8'h75;  8'h2A: lower_ascii = 8'h76;
            8'h1D: lower_ascii = 8'h77;  8'h22: lower_ascii = 8'h78;
            8'h35: lower_ascii = 8'h79;  8'h1A: lower_ascii = 8'h7A;
            default: is_letter = 1'b0;
        endcase

        is_fixed    = 1'b1;
        fixed_ascii = 8'h00;
        case (rx_data)
            8'h45: fixed_ascii = 8'h30;  8'h16: fixed_ascii = 8'h31;
            8'h1E: fixed_ascii = 8'h32;  8'h26: fixed_ascii = 8'h33;
            8'h25: fixed_ascii = 8'h34;  8'h2E: fixed_ascii = 8'h35;
            8'h36: fixed_ascii = 8'h36;  8'h3D: fixed_ascii = 8'h37;
            8'h3E: fixed_ascii = 8'h38;  8'h46: fixed_ascii = 8'h39;
            8'h29: fixed_ascii = 8'h20;  8'h5A: fixed_ascii = 8'h0D;
            8'h66: fixed_ascii = 8'h08;
            default: is_fixed = 1'b0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        lshift_next    = lshift_reg;
        rshift_next    = rshift_reg;
        caps_held_next = caps_held_reg;
        caps_next      = caps_reg;
        ev_valid_next  = 1'b0;
        ev_ascii_next  = ev_ascii_reg;
        if (read_data) begin
            if (err) begin
                state_next = ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (rx_data == 8'hF0) begin
                            state_next = ST_F0;
                        end else if (rx_data == 8'hE0) begin
                            state_next = ST_E0;
                        end else begin
                            // Translation uses modifier state from before this byte.
                            if (is_letter) begin
                                ev_valid_next = 1'b1;
                                ev_ascii_next = ((lshift_reg | rshift_reg) ^ caps_reg) ?
                                                (lower_ascii - 8'h20) : lower_ascii;
                            end else if (is_fixed) begin
                                ev_valid_next = 1'b1;
                                ev_ascii_next = fixed_ascii;
                            end
                            if (rx_data == 8'h12) lshift_next = 1'b1;
                            if (rx_data == 8'h59) rshift_next = 1'b1;
                            if (rx_data == 8'h58) begin
                                caps_held_next = 1'b1;
                                if (!caps_held_reg) caps_next = ~caps_reg;
                            end
                        end
                    end
                    ST_E0:   state_next = (rx_data == 8'hF0) ? ST_E0F0 : ST_IDLE;
                    ST_E0F0: state_next = ST_IDLE;
                    ST_F0: begin
                        state_next = ST_IDLE;
                        if (rx_data == 8'h12) lshift_next    = 1'b0;
                        if (rx_data == 8'h59) rshift_next    = 1'b0;
                        if (rx_data == 8'h58) caps_held_next = 1'b0;
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            lshift_reg    <= 1'b0;
            rshift_reg    <= 1'b0;
            caps_held_reg <= 1'b0;
            caps_reg      <= 1'b0;
            ev_valid_reg  <= 1'b0;
            ev_ascii_reg  <= 8'h00;
        end else begin
            state_reg     <= state_next;
            lshift_reg    <= lshift_next;
            rshift_reg    <= rshift_next;
            caps_held_reg <= caps_held_next;
            caps_reg      <= caps_next;
            ev_valid_reg  <= ev_valid_next;
            ev_ascii_reg  <= ev_ascii_next;
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push  = ev_valid_reg;
    assign pop   = out_valid & out_ready;
    assign wr_en = push & ((count_reg < CW'(DEPTH)) | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr_reg] <= ev_ascii_reg;
                wr_ptr_reg      <= wr_ptr_reg + 1'b1;
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !wr_en) overflow_reg <= 1'b1;
            count_reg <= count_reg + CW'(wr_en) - CW'(pop);
        end
    end

    assign out_valid  = (count_reg != '0);
    assign out_data   = out_valid ? mem[rd_ptr_reg] : 8'h00;
    assign overflow   = overflow_reg;
    assign caps_on    = caps_reg;
    assign fifo_count = count_reg;
endmodule
